// File: rtl/control_unit_pipe.sv
// control_unit_pipe: registered ID/EX control unit with handshake, memory hold FSM and flush.
// Ports: clk, rst_n, in_valid/in_ready, mode, op_code, s_in, stall_in, flush_in in;
//   out_valid, exec_cmd, mem_read, mem_write, wb_en, branch, s_out, mem_busy out.
//   Macro CU_ILLEGAL_DET_EN adds illegal_op and bubbles illegal instructions.
module control_unit_pipe #(
  parameter int CMD_W    = 4,
  parameter int MEM_WAIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [3:0]       op_code,
  input  logic             s_in,
  input  logic             stall_in,
  input  logic             flush_in,
  output logic             out_valid,
  output logic [CMD_W-1:0] exec_cmd,
  output logic             mem_read,
  output logic             mem_write,
  output logic             wb_en,
  output logic             branch,
  output logic             s_out,
  output logic             mem_busy
`ifdef CU_ILLEGAL_DET_EN
  ,
  output logic             illegal_op
`endif
);

  localparam int CNT_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT + 1) : 1;

  typedef enum logic {RUN, MEM_HOLD} state_t;

  typedef struct packed {
    logic             valid;
    logic [CMD_W-1:0] cmd;
    logic             rd;
    logic             wr;
    logic             wb;
    logic             br;
    logic             s;
  } bundle_t;

  state_t     r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  bundle_t    r_bun, w_bun_nxt, w_dec;
  logic [3:0] w_cmd4;
  logic       w_accept;
  logic       w_illegal;
  logic       r_ill, w_ill_nxt;

  always_comb begin
    w_cmd4 = 4'b0001;
    case (op_code)
      4'b1101: w_cmd4 = 4'b0001;
      4'b1111: w_cmd4 = 4'b1001;
      4'b0100: w_cmd4 = 4'b0010;
      4'b0101: w_cmd4 = 4'b0011;
      4'b0010: w_cmd4 = 4'b0100;
      4'b0110: w_cmd4 = 4'b0101;
      4'b0000: w_cmd4 = 4'b0110;
      4'b1100: w_cmd4 = 4'b0111;
      4'b0001: w_cmd4 = 4'b1000;
      4'b1010: w_cmd4 = 4'b0100;
      4'b1000: w_cmd4 = 4'b0110;
      default: w_cmd4 = 4'b0001;
    endcase
  end

`ifdef CU_ILLEGAL_DET_EN
  always_comb begin
    w_illegal = 1'b0;
    if (mode == 2'b11)
      w_illegal = 1'b1;
    else if (mode == 2'b00)
      w_illegal = !(op_code inside {4'b1101, 4'b1111,
        4'b0100, 4'b0101, 4'b0010, 4'b0110, 4'b0000,
        4'b1100, 4'b0001, 4'b1010, 4'b1000});
  end
`else
  assign w_illegal = 1'b0;
`endif

  always_comb begin
    w_dec       = '0;
    w_dec.valid = 1'b1;
    w_dec.cmd   = CMD_W'(w_cmd4);
    unique case (mode)
      2'b00: begin
        w_dec.s  = s_in;
        w_dec.wb = !(op_code == 4'b1010 ||
                     op_code == 4'b1000);
      end
      2'b01: begin
        w_dec.wb = s_in;
        w_dec.rd = s_in;
        w_dec.wr = ~s_in;
      end
      2'b10: w_dec.br = 1'b1;
      default: ;
    endcase
    // illegal instructions enter EX as bubbles
    if (w_illegal)
      w_dec = '0;
  end

  assign in_ready = (r_state == RUN) && !stall_in && !flush_in;
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bun_nxt   = r_bun;
    w_ill_nxt   = 1'b0;
    if (flush_in) begin
      w_state_nxt = RUN;
      w_cnt_nxt   = '0;
      w_bun_nxt   = '0;
    end else if (r_state == MEM_HOLD) begin
      // stall does not pause the hold count
      if (r_cnt <= CNT_W'(1)) begin
        w_state_nxt = RUN;
        w_cnt_nxt   = '0;
      end else begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
      end
    end else if (stall_in) begin
      w_bun_nxt = r_bun;
    end else if (w_accept) begin
      w_bun_nxt = w_dec;
      w_ill_nxt = w_illegal;
      if (mode == 2'b01 && MEM_WAIT > 0) begin
        w_state_nxt = MEM_HOLD;
        w_cnt_nxt   = CNT_W'(MEM_WAIT);
      end
    end else begin
      w_bun_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_cnt   <= '0;
      r_bun   <= '0;
      r_ill   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bun   <= w_bun_nxt;
      r_ill   <= w_ill_nxt;
    end
  end

  assign out_valid = r_bun.valid;
  assign exec_cmd  = r_bun.cmd;
  assign mem_read  = r_bun.rd;
  assign mem_write = r_bun.wr;
  assign wb_en     = r_bun.wb;
  assign branch    = r_bun.br;
  assign s_out     = r_bun.s;
  assign mem_busy  = (r_state == MEM_HOLD);

`ifdef CU_ILLEGAL_DET_EN
  assign illegal_op = r_ill;
`else
  logic w_unused;
  assign w_unused = r_ill;
`endif

endmodule

// File: tb/tb_control_unit_pipe.sv
// tb_control_unit_pipe: directed vectors for control_unit_pipe.
// Default parameters (CMD_W=4, MEM_WAIT=2).
module tb_control_unit_pipe;

  localparam int CMD_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, in_valid, in_ready, s_in;
  logic stall_in, flush_in;
  logic [1:0] mode;
  logic [3:0] op_code;
  logic out_valid, mem_read, mem_write;
  logic wb_en, branch, s_out, mem_busy;
  logic [CMD_W-1:0] exec_cmd;
`ifdef CU_ILLEGAL_DET_EN
  logic illegal_op;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  control_unit_pipe #(.CMD_W(CMD_W), .MEM_WAIT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .op_code(op_code), .s_in(s_in),
    .stall_in(stall_in), .flush_in(flush_in),
    .out_valid(out_valid), .exec_cmd(exec_cmd),
    .mem_read(mem_read), .mem_write(mem_write),
    .wb_en(wb_en), .branch(branch), .s_out(s_out),
    .mem_busy(mem_busy)
`ifdef CU_ILLEGAL_DET_EN
    , .illegal_op(illegal_op)
`endif
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // bundle order: valid, cmd, rd, wr, wb, br, s
  task automatic chk_b(input string tag,
                       input logic v,
                       input logic [3:0] cmd,
                       input logic rd, wr, wb, br, s);
    check(tag,
      32'({out_valid, exec_cmd, mem_read,
           mem_write, wb_en, branch, s_out}),
      32'({v, CMD_W'(cmd), rd, wr, wb, br, s}));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v,
                       input logic [1:0] m,
                       input logic [3:0] op,
                       input logic s);
    in_valid = v;
    mode     = m;
    op_code  = op;
    s_in     = s;
  endtask

  initial begin
    rst_n    = 1'b0;
    stall_in = 1'b0;
    flush_in = 1'b0;
    drive(0, 2'b00, 4'b0000, 0);
    step(); step();
    chk_b("rst_bundle", 0, 4'h0, 0, 0, 0, 0, 0);
    check("rst_busy", 32'(mem_busy), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD then asynchronous reset mid-cycle
    drive(1, 2'b00, 4'b0100, 1);
    step();
    chk_b("add", 1, 4'h2, 0, 0, 1, 0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_b("async_rst", 0, 4'h0, 0, 0, 0, 0, 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // ALU sequence
    drive(1, 2'b00, 4'b1010, 1);
    step();
    chk_b("cmp", 1, 4'h4, 0, 0, 0, 0, 1);
    drive(1, 2'b00, 4'b1111, 0);
    step();
    chk_b("mvn", 1, 4'h9, 0, 0, 1, 0, 0);
    drive(1, 2'b00, 4'b1110, 1);
    step();
    chk_b("alu_unknown", 1, 4'h1, 0, 0, 1, 0, 1);
    drive(0, 2'b00, 4'b0000, 0);
    step();
    chk_b("bubble", 0, 4'h0, 0, 0, 0, 0, 0);

    // load with two hold cycles, STR waiting behind it
    drive(1, 2'b01, 4'b0100, 1);
    step();
    chk_b("ldr_c1", 1, 4'h2, 1, 0, 1, 0, 0);
    check("ldr_busy1", 32'(mem_busy), 1);
    check("ldr_rdy1", 32'(in_ready), 0);
    drive(1, 2'b01, 4'b0100, 0);
    step();
    chk_b("ldr_c2", 1, 4'h2, 1, 0, 1, 0, 0);
    check("ldr_busy2", 32'(mem_busy), 1);
    check("ldr_rdy2", 32'(in_ready), 0);
    step();
    chk_b("ldr_c3", 1, 4'h2, 1, 0, 1, 0, 0);
    check("ldr_busy3", 32'(mem_busy), 0);
    check("ldr_rdy3", 32'(in_ready), 1);
    step();
    chk_b("str", 1, 4'h2, 0, 1, 0, 0, 0);
    check("str_busy", 32'(mem_busy), 1);

    // flush on first hold cycle of the store
    in_valid = 1'b0;
    flush_in = 1'b1;
    #1;
    check("flush_rdy", 32'(in_ready), 0);
    step();
    flush_in = 1'b0;
    #1;
    chk_b("flush", 0, 4'h0, 0, 0, 0, 0, 0);
    check("flush_busy", 32'(mem_busy), 0);
    check("flush_rdy1", 32'(in_ready), 1);

    // stall holds ORR; EOR waits
    drive(1, 2'b00, 4'b1100, 0);
    step();
    chk_b("orr", 1, 4'h7, 0, 0, 1, 0, 0);
    drive(1, 2'b00, 4'b0001, 0);
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_rdy", 32'(in_ready), 0);
      step();
      chk_b("stall_hold", 1, 4'h7, 0, 0, 1, 0, 0);
    end
    stall_in = 1'b0;
    step();
    chk_b("eor", 1, 4'h8, 0, 0, 1, 0, 0);

    // stall does not extend the memory hold
    drive(1, 2'b01, 4'b0100, 1);
    step();
    stall_in = 1'b1;
    in_valid = 1'b0;
    step();
    check("hst_busy1", 32'(mem_busy), 1);
    step();
    check("hst_busy2", 32'(mem_busy), 0);
    chk_b("hst_hold", 1, 4'h2, 1, 0, 1, 0, 0);
    stall_in = 1'b0;
    step();
    chk_b("hst_bub", 0, 4'h0, 0, 0, 0, 0, 0);

    // branch
    drive(1, 2'b10, 4'b0011, 0);
    step();
    chk_b("branch", 1, 4'h1, 0, 0, 0, 1, 0);

    // mode 11
    drive(1, 2'b11, 4'b0011, 1);
    step();
`ifdef CU_ILLEGAL_DET_EN
    chk_b("m11_bub", 0, 4'h0, 0, 0, 0, 0, 0);
    check("ill_pulse", 32'(illegal_op), 1);
    drive(0, 2'b00, 4'b0000, 0);
    step();
    check("ill_clear", 32'(illegal_op), 0);
`else
    chk_b("m11", 1, 4'h1, 0, 0, 0, 0, 0);
    drive(0, 2'b00, 4'b0000, 0);
    step();
    chk_b("m11_after", 0, 4'h0, 0, 0, 0, 0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/control_unit_pipe.md
Name: control_unit_pipe

Overview:
- Registered, stall/flush-aware successor to the combinational decode-stage control unit.
- Decodes mode/opcode/S into execute command and control strobes, then registers them into the ID/EX boundary with 1-cycle latency.
- Adds a valid/ready handshake, a multi-cycle memory-occupancy FSM, and branch flush.
- Sits between instruction decode and the execute stage of the ARM pipeline.

Parameters:
- CMD_W, 4: execute-command width; must be >= 4; decoded value is zero-extended.
- MEM_WAIT, 2: extra cycles a memory op holds the EX boundary after issue; 0 means no wait state.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  decode slot holds an instruction.
- in_ready  out  1  instruction is accepted this cycle when in_valid && in_ready.
- mode  in  2  instruction mode field: 00 ALU, 01 memory, 10 branch.
- op_code  in  4  opcode field.
- s_in  in  1  S bit; on memory ops, 1 = load and 0 = store.
- stall_in  in  1  hazard stall from the hazard unit.
- flush_in  in  1  taken-branch flush.
- out_valid  out  1  registered control bundle is a real instruction.
- exec_cmd  out  CMD_W  registered execute command.
- mem_read  out  1  registered memory read strobe.
- mem_write  out  1  registered memory write strobe.
- wb_en  out  1  registered write-back enable.
- branch  out  1  registered branch flag.
- s_out  out  1  registered flag-update enable.
- mem_busy  out  1  high while the FSM is in MEM_HOLD.

Behaviour:
- Decode table, combinational before the register:
  - MOV 1101 -> 0001; MVN 1111 -> 1001; ADD/LDR/STR 0100 -> 0010; ADC 0101 -> 0011
  - SUB 0010 -> 0100; SBC 0110 -> 0101; AND 0000 -> 0110; ORR 1100 -> 0111
  - EOR 0001 -> 1000; CMP 1010 -> 0100; TST 1000 -> 0110; any other opcode -> 0001
- Strobes by mode:
  - 00: s_out = s_in; wb_en = 1 except CMP and TST (wb_en = 0).
  - 01: wb_en = s_in; mem_read = s_in; mem_write = ~s_in.
  - 10: branch = 1.
  - 11: all strobes 0.
  - Any strobe not set by its mode row is 0.
- Reset (rst_n low, asynchronous):
  - out_valid, exec_cmd, mem_read, mem_write, wb_en, branch, s_out, mem_busy all 0.
  - FSM goes to RUN; wait counter goes to 0.
- FSM states: RUN, MEM_HOLD.
- RUN:
  - in_ready = ~stall_in.
  - Accept: register the decoded bundle with out_valid = 1.
  - No accept and no stall: load a bubble (out_valid = 0, every control output 0).
  - stall_in high: hold all output registers unchanged.
  - Accepting a mode-01 op with MEM_WAIT > 0 moves to MEM_HOLD with counter = MEM_WAIT.
- MEM_HOLD:
  - in_ready = 0; output registers hold the memory op; mem_busy = 1.
  - Counter decrements each cycle; when it reaches 1, the next edge returns to RUN.
  - stall_in does not extend or pause the count.
- Priority at each edge: flush_in > MEM_HOLD > stall_in > accept.
- flush_in:
  - Loads a bubble and forces RUN, aborting MEM_HOLD and clearing the counter.
  - in_ready = 0 in any cycle where flush_in is high.
- Back-to-back mode-01 ops: the second op is accepted on the first RUN cycle after MEM_HOLD exits.
- Latency: decode to outputs is exactly 1 cycle. A memory op occupies the EX boundary for 1 + MEM_WAIT cycles.
- Width rule: the 4-bit decode value is zero-extended to CMD_W.

Optional Feature:
- Macro CU_ILLEGAL_DET_EN.
- When defined:
  - Adds output illegal_op (1 bit, reset 0), a registered one-cycle pulse.
  - It fires when an accepted instruction has mode 11, or mode 00 with an opcode outside the table.
  - That instruction is registered as a bubble (out_valid = 0, controls 0).
- When undefined:
  - No illegal_op port.
  - Mode 11 registers with out_valid = 1 and all strobes 0.
  - Unknown ALU opcodes decode to 0001.

Test Plan:
- Reset mid-stream: ADD (mode 00, op 0100, S 1) issued, rst_n pulsed low between edges -> all outputs 0 immediately, before the next edge.
- ALU sequence, no stall: CMP (mode 00, op 1010, S 1) -> next cycle out_valid 1, exec_cmd 0100, wb_en 0, s_out 1; then MVN (op 1111, S 0) -> exec_cmd 1001, wb_en 1, s_out 0.
- Load, MEM_WAIT = 2: mode 01, op 0100, S 1 -> mem_read 1, wb_en 1, exec_cmd 0010; bundle held 3 cycles; mem_busy high 2 cycles; in_ready low 2 cycles; a following STR is issued on cycle 4 with mem_write 1.
- Stall: stall_in high 3 cycles after ORR (op 1100) -> exec_cmd 0111 held 3 cycles, in_ready 0; a pending EOR issues after stall drops with exec_cmd 1000.
- Flush during MEM_HOLD: flush_in high on the first hold cycle of a store -> next cycle out_valid 0, mem_write 0, mem_busy 0, in_ready 1.
- Branch: mode 10 accepted -> branch 1, exec_cmd 0001 (default); with CU_ILLEGAL_DET_EN, mode 11 accepted -> illegal_op pulses 1 cycle and out_valid 0.
